// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, the nop
// instruction word and the default reset program counter.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction memory is word addressed; the two low bits are always dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Request/response bus between the fetch stage (master) and a
// variable-latency instruction memory (slave).
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads when enabled, synchronous clear to a
// bubble (nop, PC+4 of zero, not valid) on reset or flush.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0] instr_reg;
  logic [31:0] pc_plus4_reg;
  logic        valid_reg;

  always_ff @(posedge clk) begin
    if (reset || (en && clr)) begin
      instr_reg    <= NOP_INSTR;
      pc_plus4_reg <= 32'h0;
      valid_reg    <= 1'b0;
    end else if (en) begin
      instr_reg    <= instr;
      pc_plus4_reg <= pc_plus4;
      valid_reg    <= 1'b1;
    end
  end

  assign InstrD   = instr_reg;
  assign PCPlus4D = pc_plus4_reg;
  assign ValidD   = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, talks to a variable-latency instruction
// memory and feeds decode, turning missing instructions into bubbles.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 PCSrcD,
  input  logic [31:0]          PCBranchD,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD,
  output logic                 FetchWaitF
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pcf_reg, pcf_next;
  logic [31:0]  drop_addr_reg, drop_addr_next;
  logic [31:0]  buf_reg, buf_next;

  logic         avail;
  logic         redirect;
  logic         ifid_clr;
  logic [31:0]  pc_plus4;
  logic [31:0]  fetched_instr;

  assign pc_plus4      = pcf_reg + 32'd4;
  assign redirect      = PCSrcD & ~StallD;
  assign avail         = ~reset & (((state_reg == RUN) & imem.imem_ready) | (state_reg == HOLD));
  assign fetched_instr = (state_reg == HOLD) ? buf_reg : imem.imem_rdata;

  assign imem.imem_req  = ~reset & (state_reg != HOLD);
  assign imem.imem_addr = (state_reg == DROP) ? drop_addr_reg : pcf_reg;
  assign FetchWaitF     = ~avail;

  // Decode gets a bubble on a taken branch or whenever nothing is available.
  assign ifid_clr = redirect | ~avail;

  always_comb begin
    state_next     = state_reg;
    pcf_next       = pcf_reg;
    drop_addr_next = drop_addr_reg;
    buf_next       = buf_reg;

    if (redirect) begin
      pcf_next = word_align(PCBranchD);
      if ((state_reg == RUN) && !imem.imem_ready) begin
        state_next     = DROP;
        drop_addr_next = pcf_reg;
      end else if ((state_reg == DROP) && !imem.imem_ready) begin
        // An earlier squashed response is still owed; keep waiting for it
        // so the address on the bus stays stable until it completes.
        state_next = DROP;
      end else begin
        state_next = RUN;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (imem.imem_ready) begin
            if (StallD) begin
              buf_next   = imem.imem_rdata;
              state_next = HOLD;
            end else if (!StallF) begin
              pcf_next = pc_plus4;
            end
          end
        end
        HOLD: begin
          if (!StallD) begin
            state_next = RUN;
            if (!StallF) begin
              pcf_next = pc_plus4;
            end
          end
        end
        DROP: begin
          if (imem.imem_ready) begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      pcf_reg       <= word_align(RESET_PC);
      drop_addr_reg <= word_align(RESET_PC);
      buf_reg       <= NOP_INSTR;
    end else begin
      state_reg     <= state_next;
      pcf_reg       <= pcf_next;
      drop_addr_reg <= drop_addr_next;
      buf_reg       <= buf_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .en       (~StallD),
    .clr      (ifid_clr),
    .instr    (fetched_instr),
    .pc_plus4 (pc_plus4),
    .InstrD   (InstrD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

endmodule
